// File: rtl/flc_pkg.sv
// Shared constants and types for the fuzzy-logic controller datapath blocks.
package flc_pkg;

    // Largest positive Q1.15 value and full-scale percentage.
    localparam int Q15_MAX  = 32767;
    localparam int PCT_MAX  = 100;

    // Default number of restoring-division iterations (one quotient bit each).
    localparam int DIV_ITER = 16;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One finished defuzzification result, as registered on the outputs.
    typedef struct packed {
        logic [15:0] y;
        logic [7:0]  pct;
        logic        div0;
        logic        sat;
    } div_result_t;

endpackage : flc_pkg

// File: rtl/defuzz_div.sv
// Defuzzifier divider: crisp output y = S_wg / S_w in Q1.15 and in percent,
// computed by a fixed-latency restoring divider (one quotient bit per cycle).
module defuzz_div
    import flc_pkg::*;
#(
    parameter int ITER = DIV_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] S_w,
    input  logic [15:0] S_wg,
    output logic        busy,
    output logic        done,
    output logic [15:0] y_q15,
    output logic [7:0]  y_pct,
    output logic        div0,
    output logic        sat
);

    // Iteration counter width; at least one bit even for ITER == 1.
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_t          state_q, state_d;

    logic [15:0]     d_q;          // latched divisor (S_w)
    logic [15:0]     n_q;          // latched dividend (S_wg)
    logic [16:0]     r_q;          // partial remainder
    logic [15:0]     q_q;          // quotient bits, MSB first
    logic [CW-1:0]   cnt_q;        // iterations remaining after this one

    logic [15:0]     y_q15_q;
    logic [7:0]      y_pct_q;
    logic            div0_q;
    logic            sat_q;

    // One restoring step on the current remainder.
    logic [16:0]     r2;
    logic            step_ge;
    logic [15:0]     q_step;
    div_result_t     res_d;

    assign r2      = r_q << 1;
    assign step_ge = (r2 >= {1'b0, d_q});
    assign q_step  = {q_q[14:0], step_ge};

    // Turns the raw 16-bit fractional quotient into the registered result,
    // handling divide-by-zero and ratio >= 1 without changing the latency.
    function automatic div_result_t finish_div(input logic [15:0] q,
                                               input logic [15:0] d,
                                               input logic [15:0] n);
        div_result_t res;
        logic [16:0] rounded;
        logic [23:0] prod;
        res     = '0;
        rounded = '0;
        if (d == 16'd0) begin
            res.div0 = 1'b1;
            res.y    = 16'd0;
        end else if (n >= d) begin
            res.sat  = 1'b1;
            res.y    = 16'(Q15_MAX);
        end else begin
            // Drop the extra fraction bit, rounding half up, then clamp.
            rounded = {2'b00, q[15:1]} + {16'd0, q[0]};
            if (rounded > 17'(Q15_MAX)) begin
                res.y = 16'(Q15_MAX);
            end else begin
                res.y = rounded[15:0];
            end
        end
        // Percent with round-half-up; 24 bits holds 32767*100 + 16384.
        prod    = ({8'd0, res.y} * 24'd100) + 24'd16384;
        res.pct = 8'(prod >> 15);
        if (res.pct > 8'(PCT_MAX)) begin
            res.pct = 8'(PCT_MAX);
        end
        return res;
    endfunction

    // Result that will be captured on the final CALC edge.
    always_comb begin
        res_d = finish_div(q_step, d_q, n_q);
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept start only in IDLE, run ITER steps, pulse DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch, restoring-division steps and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            n_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            y_q15_q <= '0;
            y_pct_q <= '0;
            div0_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        d_q   <= S_w;
                        n_q   <= S_wg;
                        r_q   <= {1'b0, S_wg};
                        q_q   <= '0;
                        cnt_q <= CW'(ITER - 1);
                    end
                end
                CALC: begin
                    if (step_ge) begin
                        r_q <= r2 - {1'b0, d_q};
                    end else begin
                        r_q <= r2;
                    end
                    q_q   <= q_step;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        y_q15_q <= res_d.y;
                        y_pct_q <= res_d.pct;
                        div0_q  <= res_d.div0;
                        sat_q   <= res_d.sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign y_q15 = y_q15_q;
    assign y_pct = y_pct_q;
    assign div0  = div0_q;
    assign sat   = sat_q;

endmodule : defuzz_div

// File: tb/tb_defuzz_div.sv
// Directed bench for defuzz_div: vector table plus busy/reset/back-to-back cases.
module tb_defuzz_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] S_w;
    logic [15:0] S_wg;
    logic        busy;
    logic        done;
    logic [15:0] y_q15;
    logic [7:0]  y_pct;
    logic        div0;
    logic        sat;

    int n_checks = 0;
    int n_fail   = 0;

    defuzz_div #(.ITER(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .S_w   (S_w),
        .S_wg  (S_wg),
        .busy  (busy),
        .done  (done),
        .y_q15 (y_q15),
        .y_pct (y_pct),
        .div0  (div0),
        .sat   (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sw;
        logic [15:0] swg;
        logic [15:0] y;
        logic [7:0]  pct;
        logic        dz;
        logic        st;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts a division now (caller is just after a negedge), scrambles the
    // operand inputs while busy, and returns the edge count until done.
    task automatic run_div(input logic [15:0] sw, input logic [15:0] swg,
                           output int lat, output bit got);
        S_w   = sw;
        S_wg  = swg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        S_w   = 16'($urandom);
        S_wg  = 16'($urandom);
        lat   = 0;
        got   = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) got = 1'b1;
        end
    endtask

    initial begin
        int  lat;
        bit  got;
        int  busy_cnt;
        int  done_cnt;

        // sw, swg, y, pct, div0, sat
        vecs[0] = '{16'd16384, 16'd8192,  16'd16384, 8'd50,  1'b0, 1'b0};
        vecs[1] = '{16'd32767, 16'd16384, 16'd16385, 8'd50,  1'b0, 1'b0};
        vecs[2] = '{16'd0,     16'd5000,  16'd0,     8'd0,   1'b1, 1'b0};
        vecs[3] = '{16'd10000, 16'd20000, 16'd32767, 8'd100, 1'b0, 1'b1};
        vecs[4] = '{16'd32767, 16'd1,     16'd1,     8'd0,   1'b0, 1'b0};
        vecs[5] = '{16'd32767, 16'd32766, 16'd32767, 8'd100, 1'b0, 1'b0};
        vecs[6] = '{16'd30000, 16'd10000, 16'd10923, 8'd33,  1'b0, 1'b0};
        vecs[7] = '{16'd12345, 16'd12345, 16'd32767, 8'd100, 1'b0, 1'b1};
        vecs[8] = '{16'd0,     16'd0,     16'd0,     8'd0,   1'b1, 1'b0};
        vecs[9] = '{16'd32768, 16'd24576, 16'd24576, 8'd75,  1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        S_w   = 16'd0;
        S_wg  = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_y",     32'(y_q15), 32'd0);
        check("reset_pct",   32'(y_pct), 32'd0);
        check("reset_div0",  32'(div0),  32'd0);
        check("reset_sat",   32'(sat),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: each vector starts in the IDLE cycle right after the previous DONE.
        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].sw, vecs[i].swg, lat, got);
            check($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd16);
            check($sformatf("v%0d_y", i),    32'(y_q15), 32'(vecs[i].y));
            check($sformatf("v%0d_pct", i),  32'(y_pct), 32'(vecs[i].pct));
            check($sformatf("v%0d_div0", i), 32'(div0),  32'(vecs[i].dz));
            check($sformatf("v%0d_sat", i),  32'(sat),   32'(vecs[i].st));
            @(negedge clk);
            check($sformatf("v%0d_done_1cyc", i), 32'(done), 32'd0);
            check($sformatf("v%0d_idle", i),      32'(busy), 32'd0);
            check($sformatf("v%0d_y_hold", i),    32'(y_q15), 32'(vecs[i].y));
            $display("vec %0d: S_wg=%0d S_w=%0d -> y_q15=%0d y_pct=%0d div0=%0d sat=%0d lat=%0d",
                     i, vecs[i].swg, vecs[i].sw, y_q15, y_pct, div0, sat, lat);
        end

        // Reset in the middle of a division: outputs clear at once, no done.
        S_w   = 16'd16384;
        S_wg  = 16'd8192;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy),  32'd0);
        check("midrst_done", 32'(done),  32'd0);
        check("midrst_y",    32'(y_q15), 32'd0);
        check("midrst_pct",  32'(y_pct), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_y_zero",  32'(y_q15),    32'd0);
        run_div(16'd4000, 16'd1000, lat, got);
        check("postrst_done_seen", 32'(got),   32'd1);
        check("postrst_latency",   32'(lat),   32'd16);
        check("postrst_y",         32'(y_q15), 32'd8192);
        check("postrst_pct",       32'(y_pct), 32'd25);
        $display("reset mid-CALC: post-reset result y_q15=%0d y_pct=%0d", y_q15, y_pct);
        @(negedge clk);

        // Start while busy is ignored; operand changes do not disturb the result.
        S_w   = 16'd16384;
        S_wg  = 16'd8192;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (c == 5) begin
                S_w   = 16'd200;
                S_wg  = 16'd100;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("busystart_done_cnt", 32'(done_cnt), 32'd1);
        check("busystart_busy_cyc", 32'(busy_cnt), 32'd17);
        check("busystart_y",        32'(y_q15),    32'd16384);
        check("busystart_pct",      32'(y_pct),    32'd50);
        $display("start while busy: done pulses=%0d busy cycles=%0d y_q15=%0d",
                 done_cnt, busy_cnt, y_q15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the flow above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_defuzz_div

// File: doc/defuzz_div.md
DEFUZZ_DIV -- requirements
Module: defuzz_div

Interface
REQ-001 Parameter ITER, default 16, number of restoring-division iterations, one fractional quotient bit per iteration.
REQ-002 Ports, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- S_w  input  16  Q1.15 weight sum from aggregator (0..32767).
- S_wg  input  16  Q1.15 weighted singleton sum from aggregator (0..32767).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse; result valid.
- y_q15  output  16  crisp output S_wg/S_w, Q1.15.
- y_pct  output  8  crisp output in percent (0..100).
- div0  output  1  last result had S_w == 0.
- sat  output  1  last result had S_wg >= S_w, S_w != 0.
REQ-003 Clock is clk and reset is rst_n; reset is asynchronous and active-low; the block has exactly one clock.

Function
REQ-004 The FSM SHALL have three states: IDLE, CALC and DONE; busy = (state != IDLE).
REQ-005 In IDLE, start=1 at edge k SHALL latch D=S_w and N=S_wg, set R=N (17 bits) and q=0, load cnt=ITER-1, and move to CALC.
REQ-006 Each CALC edge SHALL perform one restoring step: R2=R<<1; if R2>=D then R=R2-D and shift in 1, else R=R2 and shift in 0 (MSB first into 16-bit q).
REQ-007 In CALC, cnt SHALL decrement each edge; the edge with cnt==0 SHALL move to DONE and register outputs, so done is high the cycle after edge k+ITER (16 cycles after start).
REQ-008 Rounding: y_q15 = min(32767, (q>>1) + q[0]), round half up.
REQ-009 If D==0, y_q15 SHALL be 0, div0=1 and sat=0.
REQ-010 If D!=0 and N>=D, y_q15 SHALL be 32767, sat=1 and div0=0.
REQ-011 Both special cases SHALL keep the same fixed latency as a normal division.
REQ-012 y_pct SHALL be registered with y_q15 and equal (y_q15*100 + 16384) >> 15, so 32767 maps to 100.
REQ-013 DONE SHALL last exactly one cycle, assert done=1, and return to IDLE.
REQ-014 y_q15, y_pct, div0 and sat SHALL hold their values until the next DONE.
REQ-015 While busy, start SHALL be ignored, and changes on S_w/S_wg SHALL not affect the result in flight.
REQ-016 A start sampled in the IDLE cycle immediately following DONE SHALL be accepted, giving back-to-back throughput of one result per ITER+2 cycles.
REQ-017 Internal widths: R and R2 are 17 bits, D and N are 16 bits, the pct product is 24 bits; no intermediate truncation except the final >>15.

Reset
REQ-018 rst_n low SHALL asynchronously force state=IDLE and zero every output and internal register: y_q15=0, y_pct=0, done=0, busy=0, div0=0, sat=0.
REQ-019 Reset asserted mid-CALC SHALL abort the division, with no done pulse and no partial result.
REQ-020 Deassertion SHALL be honoured on the next clk edge; the first start after reset is accepted normally.

Structure
REQ-021 Shared package flc_pkg SHALL hold: Q15_MAX=32767, PCT_MAX=100, DIV_ITER=16, and the state typedef (IDLE, CALC, DONE).
REQ-022 The block SHALL be a single module with no sub-module; the restoring step is inline in the sequential process, and the rounding/pct logic is a local function.

Verification
REQ-023 Exact half: S_wg=8192, S_w=16384, start pulse -> done 16 cycles later, y_q15=16384, y_pct=50, div0=0, sat=0.
REQ-024 Rounding: S_wg=16384, S_w=32767 -> y_q15=16385, y_pct=50.
REQ-025 Special cases:
- S_w=0, S_wg=5000 -> y_q15=0, y_pct=0, div0=1, same latency.
- S_wg=20000, S_w=10000 -> y_q15=32767, y_pct=100, sat=1.
REQ-026 Start while busy: start (8192/16384), then at cycle +5 start with 100/200 -> exactly one done, y_q15=16384, busy high for 17 cycles.
REQ-027 Reset mid-CALC: rst_n low at cycle +8 -> all outputs 0 immediately and no done; the next start (1000/4000) gives y_q15=8192, y_pct=25.
